// File: rtl/lcd_pkg.sv
// Shared constants, opcodes and FSM state type for the LCD framebuffer loader.
// Optional feature macro used by the top: LCD_FB_CLEAR_EN (CLEAR fill command).
package lcd_pkg;

  localparam int RES_X    = 320;
  localparam int RES_Y    = 200;
  localparam int FB_BYTES = RES_X * RES_Y / 8;
  localparam int ADDR_W   = 16;

  // Address-width copies of the framebuffer bounds, so comparisons stay width-matched.
  localparam logic [ADDR_W-1:0] FB_DEPTH_A = ADDR_W'(FB_BYTES);
  localparam logic [ADDR_W-1:0] FB_LAST_A  = ADDR_W'(FB_BYTES - 1);

  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_SET_ADDR = 8'h2A;
  localparam logic [7:0] OP_WRITE    = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_IDLE_CS,
    ST_WRITE,
    ST_DISCARD,
    ST_CLEAR
  } fsm_state_t;

  // Framebuffer write pointer advance: the last byte wraps back to 0.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == FB_LAST_A) ? '0 : a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fb_dpram.sv
// 1bpp framebuffer RAM: one write port, one registered read port, read-first.
// Out-of-range read addresses return 0x00; out-of-range writes are ignored.
module fb_dpram #(
  parameter int DEPTH  = 8000,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [7:0]        wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [7:0]        rd
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [7:0] mem [0:DEPTH-1];
  logic [7:0] rd_q;
  logic [7:0] rd_d;

  // Select the read word (old contents on a same-address write: read-first).
  always_comb begin
    rd_d = 8'h00;
    if (ra < DEPTH_A) rd_d = mem[ra[IDX_W-1:0]];
  end

  // Memory array write, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we && (wa < DEPTH_A)) mem[wa[IDX_W-1:0]] <= wd;
  end

  // Registered read data, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= 8'h00;
    else        rd_q <= rd_d;
  end

  assign rd = rd_q;

endmodule

// File: rtl/lcd_fb_loader.sv
// SPI-slave host loader: oversampled SPI mode-0 receiver, command FSM and
// framebuffer write path. Define LCD_FB_CLEAR_EN to enable the CLEAR (0x01) fill.
module lcd_fb_loader
  import lcd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  // SPI synchronisers and edge detect
  logic [1:0] sck_sync_q, sck_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [1:0] cs_sync_q, cs_sync_d;
  logic       sck_prev_q, sck_prev_d;
  logic       sck_s, mosi_s, cs_s, sck_rise;

  // Byte assembly
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  logic       byte_stb_q, byte_stb_d;

  // Command FSM and write path
  fsm_state_t        state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [7:0]        wd_q, wd_d;
  logic              err_q, err_d;
  logic              frame_done_q, frame_done_d;
  logic [ADDR_W-1:0] set_addr;

`ifdef LCD_FB_CLEAR_EN
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

  // Shift the raw SPI pins through two flops each and keep the previous sck level.
  always_comb begin
    sck_sync_d  = {sck_sync_q[0], spi_sck};
    mosi_sync_d = {mosi_sync_q[0], spi_mosi};
    cs_sync_d   = {cs_sync_q[0], spi_cs_n};
    sck_prev_d  = sck_sync_q[1];
  end

  assign sck_s    = sck_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign cs_s     = cs_sync_q[1];
  assign sck_rise = sck_s & ~sck_prev_q;

  // Assemble MSB-first bytes on sck rising edges; a deselect drops any partial byte.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_d     = byte_q;
    byte_stb_d = 1'b0;
    if (cs_s) begin
      bit_cnt_d = 3'd0;
    end else if (sck_rise) begin
      shift_d = {shift_q[6:0], mosi_s};
      if (bit_cnt_q == 3'd7) begin
        byte_d     = {shift_q[6:0], mosi_s};
        byte_stb_d = 1'b1;
        bit_cnt_d  = 3'd0;
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end
  end

  assign set_addr = {addr_hi_q, byte_q};

  // Command decode, address pointer, write requests and CLEAR fill sequencing.
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    addr_hi_d    = addr_hi_q;
    we_d         = 1'b0;
    wa_d         = wa_q;
    wd_d         = wd_q;
    err_d        = 1'b0;
    frame_done_d = 1'b0;
`ifdef LCD_FB_CLEAR_EN
    busy_d       = busy_q;
    clr_cnt_d    = clr_cnt_q;
`endif
    if (cs_s && (state_q != ST_CLEAR)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_CMD;
        ST_CMD: begin
          if (byte_stb_q) begin
            case (byte_q)
              OP_SET_ADDR: state_d = ST_ADDR_HI;
              OP_WRITE:    state_d = ST_WRITE;
`ifdef LCD_FB_CLEAR_EN
              OP_CLEAR: begin
                state_d   = ST_CLEAR;
                busy_d    = 1'b1;
                clr_cnt_d = '0;
              end
`endif
              default: begin
                err_d   = 1'b1;
                state_d = ST_DISCARD;
              end
            endcase
          end
        end
        ST_ADDR_HI: begin
          if (byte_stb_q) begin
            addr_hi_d = byte_q;
            state_d   = ST_ADDR_LO;
          end
        end
        ST_ADDR_LO: begin
          if (byte_stb_q) begin
            if (set_addr >= FB_DEPTH_A) begin
              wr_addr_d = '0;
              err_d     = 1'b1;
            end else begin
              wr_addr_d = set_addr;
            end
            state_d = ST_IDLE_CS;
          end
        end
        ST_IDLE_CS: begin
          if (byte_stb_q) err_d = 1'b1;
        end
        ST_WRITE: begin
          if (byte_stb_q) begin
            we_d         = 1'b1;
            wa_d         = wr_addr_q;
            wd_d         = byte_q;
            frame_done_d = (wr_addr_q == FB_LAST_A);
            wr_addr_d    = next_addr(wr_addr_q);
          end
        end
        ST_DISCARD: state_d = ST_DISCARD;
        ST_CLEAR: begin
`ifdef LCD_FB_CLEAR_EN
          we_d = 1'b1;
          wa_d = clr_cnt_q;
          wd_d = 8'h00;
          if (byte_stb_q) err_d = 1'b1;
          if (clr_cnt_q == FB_LAST_A) begin
            busy_d    = 1'b0;
            wr_addr_d = '0;
            // A host still selected at the end of the fill has its remaining bytes ignored.
            state_d   = cs_s ? ST_IDLE : ST_DISCARD;
          end else begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          end
`else
          state_d = ST_IDLE;
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control and status registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q   <= 2'b00;
      mosi_sync_q  <= 2'b00;
      cs_sync_q    <= 2'b11;
      sck_prev_q   <= 1'b0;
      bit_cnt_q    <= 3'd0;
      byte_stb_q   <= 1'b0;
      state_q      <= ST_IDLE;
      wr_addr_q    <= '0;
      addr_hi_q    <= 8'h00;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sck_sync_q   <= sck_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      cs_sync_q    <= cs_sync_d;
      sck_prev_q   <= sck_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_stb_q   <= byte_stb_d;
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      addr_hi_q    <= addr_hi_d;
      we_q         <= we_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Data-path registers carry no reset; they are qualified by strobes and enables.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    byte_q  <= byte_d;
    wa_q    <= wa_d;
    wd_q    <= wd_d;
  end

`ifdef LCD_FB_CLEAR_EN
  // CLEAR fill counter and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      clr_cnt_q <= '0;
    end else begin
      busy_q    <= busy_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end
  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

  assign err        = err_q;
  assign frame_done = frame_done_q;

  fb_dpram #(
    .DEPTH (FB_BYTES),
    .ADDR_W(ADDR_W)
  ) u_fb_dpram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we_q),
    .wa   (wa_q),
    .wd   (wd_q),
    .ra   (rd_addr),
    .rd   (rd_data)
  );

endmodule

// File: tb/tb_lcd_fb_loader.sv
// Directed plus randomized bench for lcd_fb_loader against a byte-array framebuffer model.
module tb_lcd_fb_loader;
  import lcd_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              spi_sck = 1'b0;
  logic              spi_mosi = 1'b0;
  logic              spi_cs_n = 1'b1;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [7:0]        rd_data;
  logic              busy, frame_done, err;

  lcd_fb_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_cs_n  (spi_cs_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .frame_done(frame_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int err_cnt = 0;
  int fd_cnt = 0;
  int busy_cyc = 0;

  // Pulse and busy-duration monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (err === 1'b1) err_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
    if (busy === 1'b1) busy_cyc++;
  end

  // Reference model: framebuffer contents and the host-visible write pointer.
  logic [7:0] model [FB_BYTES];
  bit         known [FB_BYTES];
  int         m_addr = 0;
  int         m_fd = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      clks(4);
      spi_sck = 1'b1;
      clks(4);
      spi_sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic cs_lo();
    spi_cs_n = 1'b0;
    clks(4);
  endtask

  task automatic cs_hi();
    clks(4);
    spi_cs_n = 1'b1;
    clks(8);
  endtask

  task automatic set_addr(input int a);
    cs_lo();
    send_byte(OP_SET_ADDR);
    send_byte(8'((a >> 8) & 255));
    send_byte(8'(a & 255));
    cs_hi();
    m_addr = (a >= FB_BYTES) ? 0 : a;
  endtask

  logic [7:0] wq [$];

  task automatic write_q();
    cs_lo();
    send_byte(OP_WRITE);
    foreach (wq[i]) begin
      send_byte(wq[i]);
      model[m_addr] = wq[i];
      known[m_addr] = 1'b1;
      if (m_addr == FB_BYTES - 1) m_fd++;
      m_addr = (m_addr + 1) % FB_BYTES;
    end
    cs_hi();
  endtask

  task automatic read_chk(input string tag, input int a, input logic [7:0] exp);
    rd_addr = ADDR_W'(a);
    clks(1);
    check(tag, rd_data, exp);
  endtask

  int e0, f0, b0, a0, n, t;

  initial begin
    // Reset state
    clks(3);
    check("rst_rd_data", rd_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    clks(20);
    check("idle_err_cnt", err_cnt, 0);
    check("idle_busy_cyc", busy_cyc, 0);

    // SET_ADDR 40, WRITE A5 3C
    e0 = err_cnt;
    set_addr(40);
    wq = '{8'hA5, 8'h3C};
    write_q();
    read_chk("wr40", 40, 8'hA5);
    read_chk("wr41", 41, 8'h3C);
    check("wr_err", err_cnt - e0, 0);

    // Last-byte wrap with frame_done
    f0 = fd_cnt;
    set_addr(7999);
    wq = '{8'h11, 8'h22};
    write_q();
    check("fd_pulse", fd_cnt - f0, 1);
    read_chk("wrap7999", 7999, 8'h11);
    read_chk("wrap0", 0, 8'h22);

    // Out-of-range SET_ADDR
    e0 = err_cnt;
    set_addr(8000);
    check("oob_err", err_cnt - e0, 1);
    wq = '{8'h77};
    write_q();
    read_chk("oob_wr0", 0, 8'h77);

    // Unknown opcode followed by data
    e0 = err_cnt;
    cs_lo();
    send_byte(8'h55);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    cs_hi();
    check("badop_err", err_cnt - e0, 1);
    read_chk("badop_ram", 41, 8'h3C);

    // Extra byte after SET_ADDR
    e0 = err_cnt;
    cs_lo();
    send_byte(OP_SET_ADDR);
    send_byte(8'h00);
    send_byte(8'd100);
    send_byte(8'hEE);
    cs_hi();
    m_addr = 100;
    check("idlecs_err", err_cnt - e0, 1);

    // Partial byte dropped, pointer kept
    wq = '{8'h5A};
    write_q();
    set_addr(100);
    cs_lo();
    send_byte(OP_WRITE);
    send_bits(8'hFF, 4);
    cs_hi();
    read_chk("partial_ram", 100, 8'h5A);
    wq = '{8'hC3};
    write_q();
    read_chk("partial_ptr", 100, 8'hC3);

    // Randomized bursts against the model
    for (int it = 0; it < 8; it++) begin
      a0 = (it % 3 == 0) ? FB_BYTES - 1 - int'($urandom_range(0, 3)) : int'($urandom_range(0, FB_BYTES - 1));
      n = int'($urandom_range(1, 6));
      e0 = err_cnt;
      f0 = fd_cnt;
      m_fd = 0;
      set_addr(a0);
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
      write_q();
      check("rnd_fd", fd_cnt - f0, m_fd);
      check("rnd_err", err_cnt - e0, 0);
      for (int k = 0; k < n; k++) begin
        t = (a0 + k) % FB_BYTES;
        read_chk("rnd_rd", t, model[t]);
      end
      read_chk("rnd_oob_rd", FB_BYTES + int'($urandom_range(0, 1000)), 8'h00);
    end

`ifdef LCD_FB_CLEAR_EN
    // CLEAR fill with a byte sent mid-fill
    e0 = err_cnt;
    b0 = busy_cyc;
    cs_lo();
    send_byte(OP_CLEAR);
    send_byte(8'h5A);
    cs_hi();
    t = 0;
    while (busy === 1'b1 && t < 20000) begin
      clks(1);
      t++;
    end
    check("clr_timeout", (t < 20000), 1);
    clks(4);
    check("clr_busy_len", busy_cyc - b0, FB_BYTES);
    check("clr_err", err_cnt - e0, 1);
    for (int i = 0; i < FB_BYTES; i++) begin
      model[i] = 8'h00;
      known[i] = 1'b1;
    end
    m_addr = 0;
    for (int i = 0; i < FB_BYTES; i++) read_chk("clr_ram", i, model[i]);
    wq = '{8'h99};
    write_q();
    read_chk("clr_ptr0", 0, 8'h99);
`else
    // 0x01 is an unknown opcode in this build
    e0 = err_cnt;
    cs_lo();
    send_byte(OP_CLEAR);
    send_byte(8'h5A);
    cs_hi();
    check("noclr_err", err_cnt - e0, 1);
    check("noclr_busy", busy_cyc, 0);
    read_chk("noclr_ram", 40, 8'hA5);
`endif

    // Asynchronous reset mid-run
    rst_n = 1'b0;
    #2;
    check("rst2_rd_data", rd_data, 0);
    check("rst2_busy", busy, 0);
    check("rst2_err", err, 0);
    clks(2);
    rst_n = 1'b1;
    clks(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
